// File: rtl/lfsr_key_scheduler_if.sv
// ---------------------------------------------------------------------------
// lfsr_key_scheduler_if
// Bundles the requester-facing signals of the LFSR key scheduler.
//   seed_load  : load seed_in into the LFSR (accepted only while idle)
//   seed_in    : 6-bit seed value
//   req        : level request per requester
//   grant      : one-hot owner of the current key cycle, zero when idle
//   key_out    : delivered key word, valid with key_valid
//   key_valid  : one-cycle strobe for key_out
//   busy       : a key cycle is in progress
//   lfsr_state : live LFSR contents for seed save-back
// master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface lfsr_key_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic               seed_load;
    logic [5:0]         seed_in;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [5:0]         key_out;
    logic               key_valid;
    logic               busy;
    logic [5:0]         lfsr_state;

    modport master (
        output seed_load, seed_in, req,
        input  grant, key_out, key_valid, busy, lfsr_state
    );

    modport slave (
        input  seed_load, seed_in, req,
        output grant, key_out, key_valid, busy, lfsr_state
    );
endinterface

// File: rtl/lfsr_key_scheduler.sv
// ---------------------------------------------------------------------------
// lfsr_key_scheduler
// Shares one 6-bit Fibonacci LFSR between NUM_REQ requesters. A round-robin
// arbiter picks one requester in IDLE, the LFSR is stepped STEPS_PER_KEY
// times, and the stepped value is returned with a one-cycle key_valid.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lfsr_key_scheduler_if.slave (seed, req, grant, key, status)
// ---------------------------------------------------------------------------
module lfsr_key_scheduler #(
    parameter int         NUM_REQ       = 2,
    parameter int         STEPS_PER_KEY = 3,
    parameter logic [5:0] DEFAULT_SEED  = 6'b000001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lfsr_key_scheduler_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         lfsr_q, lfsr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [5:0]         key_q, key_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [5:0]         lfsr_stepped;

    // Shift right, feedback (bit0 ^ bit1) enters at the MSB.
    assign lfsr_stepped = {lfsr_q[0] ^ lfsr_q[1], lfsr_q[5:1]};

    // Round-robin search starting just after the last winner. Iterating from
    // the farthest candidate down to the nearest lets the nearest one win.
    always_comb begin
        logic [PTR_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        key_d   = key_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.seed_load) begin
                    // A zero seed would lock the LFSR, so it is replaced.
                    lfsr_d = (bus.seed_in == 6'd0) ? DEFAULT_SEED : bus.seed_in;
                end else if (win_found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    ptr_d   = win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = STEP;
                end
            end
            STEP: begin
                lfsr_d = lfsr_stepped;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(STEPS_PER_KEY - 1)) begin
                    key_d   = lfsr_stepped;
                    valid_d = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                valid_d = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= 4'd0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            grant_q <= '0;
            key_q   <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.key_out    = key_q;
    assign bus.key_valid  = valid_q;
    assign bus.busy       = busy_q;
    assign bus.lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_key_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lfsr_key_scheduler
// Directed and randomized transactions against a transaction-level model:
// the model keeps the LFSR as an integer, steps it arithmetically, and picks
// the round-robin winner by scanning requesters after the last winner.
// ---------------------------------------------------------------------------
module tb_lfsr_key_scheduler;
    localparam int         NR    = 2;
    localparam int         STEPS = 3;
    localparam logic [5:0] DEF   = 6'b000001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_key_scheduler_if #(.NUM_REQ(NR)) bus ();

    lfsr_key_scheduler #(
        .NUM_REQ      (NR),
        .STEPS_PER_KEY(STEPS),
        .DEFAULT_SEED (DEF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_vcyc;

    // Reference model state
    int m_lfsr;
    int m_ptr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lfsr_step(input int s);
        return (((s ^ (s >> 1)) & 1) * 32) + (s >> 1);
    endfunction

    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            if (r[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_lfsr = DEF;
        m_ptr  = NR - 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_grant"}, bus.grant, 0);
        check_val({tag, "_key"}, bus.key_out, 0);
        check_val({tag, "_valid"}, bus.key_valid, 0);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_lfsr"}, bus.lfsr_state, DEF);
    endtask

    task automatic do_reset;
        bus.req       = '0;
        bus.seed_load = 1'b0;
        bus.seed_in   = 6'd0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_outputs("reset");
        $display("reset released");
    endtask

    // One key transaction from IDLE. mode 1 pulses seed_load during STEP;
    // drop releases req right after the grant; hold keeps req for the next key.
    task automatic run_key(input logic [NR-1:0] r, input int mode,
                           input logic drop, input logic hold);
        int w;
        int n;
        int exp_key;
        bus.req = r;
        w = pick(r);
        tick();
        check_val("grant", bus.grant, 1 << w);
        check_val("busy", bus.busy, 1);
        m_ptr   = w;
        exp_key = m_lfsr;
        for (int s = 0; s < STEPS; s++) exp_key = lfsr_step(exp_key);
        m_lfsr = exp_key;
        if (drop) bus.req = '0;
        n = 0;
        while (!bus.key_valid && n < 20) begin
            bus.seed_load = (mode == 1 && n == 1);
            bus.seed_in   = 6'($urandom);
            tick();
            n++;
        end
        bus.seed_load = 1'b0;
        check_val("latency", n, STEPS);
        check_val("key_out", bus.key_out, exp_key);
        check_val("key_grant", bus.grant, 1 << w);
        check_val("lfsr_state", bus.lfsr_state, exp_key);
        $display("key: req=%b grant=%b key=%b exp=%b mode=%0d drop=%0d",
                 r, bus.grant, bus.key_out, 6'(exp_key), mode, drop);
        last_vcyc = cyc;
        if (!hold) bus.req = '0;
        tick();
        check_val("valid_off", bus.key_valid, 0);
        check_val("grant_off", bus.grant, 0);
        check_val("busy_off", bus.busy, 0);
    endtask

    task automatic load_seed(input logic [5:0] s, input logic [NR-1:0] r);
        bus.seed_load = 1'b1;
        bus.seed_in   = s;
        bus.req       = r;
        tick();
        bus.seed_load = 1'b0;
        bus.req       = '0;
        m_lfsr = (s == 6'd0) ? DEF : int'(s);
        check_val("seed_grant", bus.grant, 0);
        check_val("seed_busy", bus.busy, 0);
        check_val("seed_lfsr", bus.lfsr_state, m_lfsr);
        $display("seed: in=%b req=%b lfsr=%b", s, r, bus.lfsr_state);
    endtask

    task automatic reset_mid_step;
        bus.req = 2'b01;
        tick();            // grant edge
        tick();            // first step edge, now in second step cycle
        #2 rst_n = 1'b0;
        bus.req = '0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        repeat (2) begin
            tick();
            check_val("midrst_novalid", bus.key_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset during STEP done");
    endtask

    initial begin
        int prev;
        int act;
        logic [5:0] sd;
        do_reset();

        // First key from default seed, then back-to-back second key.
        run_key(2'b01, 0, 1'b0, 1'b1);
        check_val("first_key_const", bus.lfsr_state, 6'b001000);
        prev = last_vcyc;
        run_key(2'b01, 0, 1'b0, 1'b0);
        check_val("second_key_const", bus.lfsr_state, 6'b100001);
        check_val("key_spacing", last_vcyc - prev, STEPS + 2);

        // Seed load with priority over req, then requester 1.
        load_seed(6'b101101, 2'b11);
        run_key(2'b10, 0, 1'b0, 1'b0);
        check_val("seeded_key_const", bus.lfsr_state, 6'b011101);

        // Zero seed is replaced.
        load_seed(6'b000000, 2'b00);
        run_key(2'b01, 0, 1'b0, 1'b0);

        // Both requesting from reset: grants alternate.
        do_reset();
        for (int i = 0; i < 4; i++) run_key(2'b11, 0, 1'b0, 1'b1);
        bus.req = '0;
        tick();

        // Reset in the middle of STEP, then a fresh key.
        reset_mid_step();
        run_key(2'b01, 0, 1'b0, 1'b0);

        // seed_load during STEP ignored; dropped req still completes.
        run_key(2'b11, 1, 1'b0, 1'b0);
        run_key(2'b10, 0, 1'b1, 1'b0);

        // Idle with no request: nothing moves.
        tick();
        check_val("idle_busy", bus.busy, 0);
        check_val("idle_lfsr", bus.lfsr_state, m_lfsr);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            act = $urandom_range(0, 7);
            if (act == 0) begin
                sd = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
                load_seed(sd, NR'($urandom));
            end else if (act == 1) begin
                bus.req = '0;
                tick();
                check_val("rand_idle_busy", bus.busy, 0);
            end else begin
                run_key(NR'($urandom_range(1, (1 << NR) - 1)),
                        ($urandom_range(0, 3) == 0) ? 1 : 0,
                        ($urandom_range(0, 4) == 0),
                        ($urandom_range(0, 1) == 1));
            end
        end
        bus.req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lfsr_key_scheduler.md
Name: lfsr_key_scheduler

Overview:
- Owns one 6-bit Fibonacci LFSR key source and shares it between NUM_REQ requesters, e.g. the encrypt and decrypt paths.
- Round-robin arbitration grants one requester at a time.
- For each grant, the block steps the LFSR STEPS_PER_KEY times and returns the resulting 6-bit key word with a one-cycle valid strobe.
- Also handles seed loading and exposes the live LFSR state so the seed can be saved off-chip.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- STEPS_PER_KEY, 3, LFSR shifts per delivered key (1..15).
- DEFAULT_SEED, 6'b000001, reset value of the LFSR; also substituted for an all-zero seed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed_load  input  1  load seed_in into the LFSR; honoured only in IDLE.
- seed_in  input  6  seed value.
- req  input  NUM_REQ  level request per requester; held until its key_valid, may stay high for another key.
- grant  output  NUM_REQ  one-hot owner of the current key cycle; all-zero when idle.
- key_out  output  6  delivered key word, valid when key_valid=1.
- key_valid  output  1  one-cycle strobe; the key belongs to the requester in grant.
- busy  output  1  high in STEP and DELIVER.
- lfsr_state  output  6  current LFSR contents, for seed save-back.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, lfsr=DEFAULT_SEED, grant=0, key_out=0, key_valid=0, busy=0.
  - Step counter=0; round-robin pointer=NUM_REQ-1, so requester 0 wins first.
- LFSR step:
  - next = {lfsr[0]^lfsr[1], lfsr[5:1]} (shift right, feedback into MSB).
  - Steps only in STEP state, one per clock.
- All outputs are registered.
- FSM IDLE:
  - seed_load=1: lfsr <= (seed_in==0 ? DEFAULT_SEED : seed_in); stay IDLE; no grant this cycle. seed_load has priority over req.
  - Else if any req: pick the first requester set, searching from pointer+1 modulo NUM_REQ.
  - Register grant one-hot, update the pointer to the winner, set busy, clear the counter, go to STEP.
- FSM STEP:
  - lfsr advances each cycle; counter increments.
  - After the STEPS_PER_KEY-th step edge, go to DELIVER.
  - On that same edge key_out <= stepped value and key_valid <= 1.
- FSM DELIVER:
  - Lasts exactly one cycle; key_valid=1 and grant held.
  - Next edge: key_valid=0, grant=0, busy=0, state=IDLE.
- Latency:
  - req sampled in IDLE at edge E0; grant visible after E0.
  - key_valid is high from edge E(STEPS_PER_KEY) to E(STEPS_PER_KEY+1).
  - Default: key_valid is high in the 4th cycle after E0.
  - Minimum spacing between keys is STEPS_PER_KEY+2 cycles, since one IDLE cycle always separates grants.
- Request handling during a key cycle:
  - req changes during STEP/DELIVER are ignored until the next IDLE.
  - Dropping req mid-cycle does not abort; the key is still delivered and discarded by the requester.
- seed_load outside IDLE is ignored, not queued.
- lfsr_state always mirrors the internal register.
- The LFSR never reaches all-zero, because the only zero entry path (seed) is guarded.
- Reset asserted mid-operation: immediate return to reset values; the in-flight key is lost, no key_valid issued, and the pointer resets.

Test Plan:
- Reset, then req=2'b01 with no seed load -> grant=01 after E0; key_valid in 4th cycle; key_out=6'b001000; lfsr_state=001000.
- Keep req=2'b01 high after the first key -> second key_out=6'b100001; exactly one IDLE cycle between the two key_valid strobes.
- seed_load=1, seed_in=6'b101101 in IDLE, then req=2'b10 -> grant=10; key_out=6'b011101.
- seed_in=6'b000000 with seed_load -> lfsr_state=000001; the following key is 6'b001000.
- req=2'b11 held continuously from reset -> grants alternate 01,10,01,10.
  - Keys in order: 001000, 100001, then continuing the LFSR sequence.
  - Each key_valid coincides with the matching grant.
- Assert rst_n low during STEP (second step cycle); also pulse seed_load during STEP in a separate run.
  - Reset run: outputs return to reset values immediately; no key_valid; the next request yields 001000.
  - seed_load during STEP: ignored; the key is unchanged.
